decoded_instr_queue: RTL and testbench

DECODED_INSTR_QUEUE -- requirements
Module: decoded_instr_queue

---
 rtl/Purple_Jade_pkg.sv | 19 +
 rtl/queue_mem.sv | 24 ++
 rtl/decoded_instr_queue.sv | 78 +++++++
 tb/tb_decoded_instr_queue.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/Purple_Jade_pkg.sv
// Shared front-end/back-end definitions for the Purple Jade core.
// Holds the decoded instruction bundle and front-end queue sizing.
package Purple_Jade_pkg;

  localparam int FE_QUEUE_ELS = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } decoded_instruction_t;

  localparam int DECODED_INSTRUCTION_WIDTH =
    $bits(decoded_instruction_t);

endpackage

// File: rtl/queue_mem.sv
// Queue storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally left unreset.
module queue_mem #(
  parameter int ELS_P   = 8,
  parameter int WIDTH_P = 32,
  localparam int AW     = $clog2(ELS_P)
) (
  input  logic               clk_i,
  input  logic               w_v_i,
  input  logic [AW-1:0]      w_addr_i,
  input  logic [WIDTH_P-1:0] w_data_i,
  input  logic [AW-1:0]      r_addr_i,
  output logic [WIDTH_P-1:0] r_data_o
);

  logic [WIDTH_P-1:0] mem_q [ELS_P];

  always_ff @(posedge clk_i) begin
    if (w_v_i) mem_q[w_addr_i] <= w_data_i;
  end

  assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/decoded_instr_queue.sv
// Front-end to back-end decoded instruction FIFO.
// Wrap-bit pointers; flush and async reset both zero the pointers.
module decoded_instr_queue
  import Purple_Jade_pkg::*;
#(
  parameter int ELS_P   = FE_QUEUE_ELS,
  parameter int WIDTH_P = DECODED_INSTRUCTION_WIDTH,
  localparam int AW     = $clog2(ELS_P),
  localparam int PW     = AW + 1,
  localparam int CW     = $clog2(ELS_P + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               flush_i,
  input  logic               v_i,
  input  logic [WIDTH_P-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [WIDTH_P-1:0] data_o,
  input  logic               ready_i,
  output logic [CW-1:0]      count_o,
  output logic               almost_full_o
);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] cnt;
  logic          empty, full, enq, deq;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0])
              && (wptr_q[AW] != rptr_q[AW]);

  // ready_o depends only on registered pointers
  assign ready_o = ~full;
  assign v_o     = ~empty & ~flush_i;
  assign enq     = v_i & ~full & ~flush_i;
  assign deq     = v_o & ready_i;

  assign cnt           = wptr_q - rptr_q;
  assign count_o       = CW'(cnt);
  assign almost_full_o = (cnt >= PW'(ELS_P - 1));

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (enq) wptr_d = wptr_q + PW'(1);
      if (deq) rptr_d = rptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  queue_mem #(
    .ELS_P  (ELS_P),
    .WIDTH_P(WIDTH_P)
  ) u_mem (
    .clk_i   (clk_i),
    .w_v_i   (enq),
    .w_addr_i(wptr_q[AW-1:0]),
    .w_data_i(data_i),
    .r_addr_i(rptr_q[AW-1:0]),
    .r_data_o(data_o)
  );

endmodule

// File: tb/tb_decoded_instr_queue.sv
// Directed bench for decoded_instr_queue with a queue-based scoreboard.
// Each step checks outputs against the model before the clock edge.
module tb_decoded_instr_queue;
  import Purple_Jade_pkg::*;

  localparam int W   = DECODED_INSTRUCTION_WIDTH;
  localparam int ELS = FE_QUEUE_ELS;
  localparam int CW  = $clog2(ELS + 1);

  logic          clk = 1'b0;
  logic          reset_i, flush_i, v_i, ready_i;
  logic [W-1:0]  data_i;
  logic          ready_o, v_o, almost_full_o;
  logic [W-1:0]  data_o;
  logic [CW-1:0] count_o;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] sb [$];

  decoded_instr_queue dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .flush_i      (flush_i),
    .v_i          (v_i),
    .data_i       (data_i),
    .ready_o      (ready_o),
    .v_o          (v_o),
    .data_o       (data_o),
    .ready_i      (ready_i),
    .count_o      (count_o),
    .almost_full_o(almost_full_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  task automatic check_model(input logic f);
    int  n;
    logic ev;
    n  = sb.size();
    ev = (n != 0) && !f;
    chk("v_o", 128'(v_o), 128'(ev));
    chk("ready_o", 128'(ready_o), 128'(n != ELS));
    chk("count_o", 128'(count_o), 128'(n));
    chk("almost_full_o", 128'(almost_full_o), 128'(n >= ELS - 1));
    if (ev) chk("data_o", 128'(data_o), 128'(sb[0]));
  endtask

  // Drive one cycle, check pre-edge outputs, then advance the model
  task automatic step(input logic v, input logic [W-1:0] d,
                      input logic r, input logic f);
    logic do_enq, do_deq;
    v_i = v; data_i = d; ready_i = r; flush_i = f;
    #2;
    check_model(f);
    do_deq = (sb.size() != 0) && !f && r;
    do_enq = v && (sb.size() != ELS) && !f;
    @(posedge clk);
    if (f) sb.delete();
    else begin
      if (do_deq) void'(sb.pop_front());
      if (do_enq) sb.push_back(d);
    end
    #1;
  endtask

  initial begin
    reset_i = 1'b1; flush_i = 1'b0; v_i = 1'b0;
    ready_i = 1'b0; data_i = '0;
    #3;
    chk("rst_count", 128'(count_o), 128'(0));
    chk("rst_v", 128'(v_o), 128'(0));
    chk("rst_ready", 128'(ready_o), 128'(1));
    chk("rst_af", 128'(almost_full_o), 128'(0));
    #9;
    reset_i = 1'b0;

    // three entries held, then drained in order
    step(1, W'(32'hA), 0, 0);
    step(1, W'(32'hB), 0, 0);
    step(1, W'(32'hC), 0, 0);
    step(0, '0, 0, 0);
    chk("three_count", 128'(count_o), 128'(3));
    chk("three_head", 128'(data_o), 128'(32'hA));
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0);
    chk("drained_v", 128'(v_o), 128'(0));

    // fill, then enqueue blocked during the freeing dequeue
    for (int i = 0; i < ELS; i++) step(1, rnd(), 0, 0);
    chk("full_ready", 128'(ready_o), 128'(0));
    chk("full_af", 128'(almost_full_o), 128'(1));
    step(1, rnd(), 1, 0);
    chk("after_full_count", 128'(count_o), 128'(ELS - 1));
    chk("after_full_ready", 128'(ready_o), 128'(1));
    for (int i = 0; i < ELS; i++) step(0, '0, 1, 0);

    // streaming through the wrap point
    for (int i = 0; i < 20; i++) step(1, rnd(), 1, 0);
    chk("stream_count", 128'(count_o), 128'(1));
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);

    // flush beats a concurrent enqueue and dequeue
    for (int i = 0; i < 5; i++) step(1, rnd(), 0, 0);
    step(1, rnd(), 1, 1);
    chk("flush_count", 128'(count_o), 128'(0));
    step(0, '0, 1, 0);

    // async reset pulse between edges
    for (int i = 0; i < 4; i++) step(1, rnd(), 0, 0);
    reset_i = 1'b1;
    #1;
    chk("arst_v", 128'(v_o), 128'(0));
    chk("arst_count", 128'(count_o), 128'(0));
    chk("arst_ready", 128'(ready_o), 128'(1));
    #1;
    reset_i = 1'b0;
    sb.delete();
    step(1, W'(32'h5A5A), 0, 0);
    step(0, '0, 0, 0);
    chk("post_rst_data", 128'(data_o), 128'(32'h5A5A));
    chk("post_rst_count", 128'(count_o), 128'(1));
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
